// File: rtl/mux_4a1.sv
// 3-to-1 32-bit selector (Ctrl=3 reserved, yields zero) with registered copy and sticky reserved-code flag.
// Optional feature: define MUX_4A1_SEL_ERR_EN to build the Sel_Err register; otherwise Sel_Err is tied low.
module mux_4a1 (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Ctrl,
   input  logic [31:0] Entrada1,
   input  logic [31:0] Entrada2,
   input  logic [31:0] Entrada3,
   output logic [31:0] Mux_Out,
   output logic [31:0] Mux_Out_r,
   output logic        Sel_Err
);

   logic [31:0] w_mux;

   // Unknown Ctrl propagates X in simulation; synthesis sees it as don't-care.
   always_comb begin
      w_mux = '0;
      case (Ctrl)
         2'd0:    w_mux = Entrada1;
         2'd1:    w_mux = Entrada2;
         2'd2:    w_mux = Entrada3;
         2'd3:    w_mux = '0;
         default: w_mux = 'x;
      endcase
   end

   assign Mux_Out = w_mux;

   logic [31:0] r_mux_out;

   always_ff @(posedge clk) begin
      if (reset) r_mux_out <= '0;
      else       r_mux_out <= w_mux;
   end

   assign Mux_Out_r = r_mux_out;

`ifdef MUX_4A1_SEL_ERR_EN
   logic r_sel_err;

   always_ff @(posedge clk) begin
      if (reset)             r_sel_err <= 1'b0;
      else if (Ctrl == 2'd3) r_sel_err <= 1'b1;
   end

   assign Sel_Err = r_sel_err;
`else
   assign Sel_Err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_4a1.sv
// Directed self-checking bench for mux_4a1; Sel_Err expectations follow MUX_4A1_SEL_ERR_EN.
module tb_mux_4a1;

   logic        clk;
   logic        clk_run;
   logic        reset;
   logic [1:0]  Ctrl;
   logic [31:0] Entrada1;
   logic [31:0] Entrada2;
   logic [31:0] Entrada3;
   logic [31:0] Mux_Out;
   logic [31:0] Mux_Out_r;
   logic        Sel_Err;

   int unsigned checks;
   int unsigned errors;

`ifdef MUX_4A1_SEL_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   mux_4a1 dut (
      .clk      (clk),
      .reset    (reset),
      .Ctrl     (Ctrl),
      .Entrada1 (Entrada1),
      .Entrada2 (Entrada2),
      .Entrada3 (Entrada3),
      .Mux_Out  (Mux_Out),
      .Mux_Out_r(Mux_Out_r),
      .Sel_Err  (Sel_Err)
   );

   // Clock only toggles once clk_run is raised, so the combinational test sees no edges.
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_comb();
      logic [31:0] exp_tab [3];
      exp_tab[0] = 32'd1;
      exp_tab[1] = 32'd2;
      exp_tab[2] = 32'd3;
      Entrada1 = 32'd1;
      Entrada2 = 32'd2;
      Entrada3 = 32'd3;
      for (int i = 0; i < 3; i++) begin
         Ctrl = 2'(i);
         #10;
         checks++;
         if (Mux_Out !== exp_tab[i]) begin
            errors++;
            $display("FAIL comb_sel%0d: got %h expected %h", i, Mux_Out, exp_tab[i]);
         end
      end
      Ctrl = 2'd3;
      #10;
      checks++;
      if (Mux_Out !== 32'h0) begin
         errors++;
         $display("FAIL comb_reserved: got %h expected %h", Mux_Out, 32'h0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      Ctrl  = 2'd0;
      tick();
      checks++;
      if (Mux_Out_r !== 32'h0) begin
         errors++;
         $display("FAIL reset_mux_r: got %h expected %h", Mux_Out_r, 32'h0);
      end
      checks++;
      if (Sel_Err !== 1'b0) begin
         errors++;
         $display("FAIL reset_sel_err: got %b expected %b", Sel_Err, 1'b0);
      end
      reset = 1'b0;
   endtask

   task automatic test_reserved();
      Entrada1 = 32'd1;
      Entrada2 = 32'd2;
      Entrada3 = 32'd3;
      Ctrl     = 2'd0;
      tick();
      checks++;
      if (Mux_Out_r !== 32'd1) begin
         errors++;
         $display("FAIL reserved_pre_r: got %h expected %h", Mux_Out_r, 32'd1);
      end
      Ctrl = 2'd3;
      #1;
      checks++;
      if (Mux_Out !== 32'h0) begin
         errors++;
         $display("FAIL reserved_comb: got %h expected %h", Mux_Out, 32'h0);
      end
      tick();
      checks++;
      if (Mux_Out_r !== 32'h0) begin
         errors++;
         $display("FAIL reserved_r: got %h expected %h", Mux_Out_r, 32'h0);
      end
      checks++;
      if (Sel_Err !== ERR_ON) begin
         errors++;
         $display("FAIL reserved_sel_err: got %b expected %b", Sel_Err, ERR_ON);
      end
   endtask

   task automatic test_registered();
      Entrada2 = 32'hDEAD_BEEF;
      Entrada3 = 32'h1234_5678;
      Ctrl     = 2'd1;
      tick();
      checks++;
      if (Mux_Out_r !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL reg_load: got %h expected %h", Mux_Out_r, 32'hDEAD_BEEF);
      end
      #2;
      Ctrl = 2'd2;
      #1;
      checks++;
      if (Mux_Out_r !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL reg_hold: got %h expected %h", Mux_Out_r, 32'hDEAD_BEEF);
      end
      checks++;
      if (Mux_Out !== 32'h1234_5678) begin
         errors++;
         $display("FAIL reg_comb_track: got %h expected %h", Mux_Out, 32'h1234_5678);
      end
      tick();
      checks++;
      if (Mux_Out_r !== 32'h1234_5678) begin
         errors++;
         $display("FAIL reg_next: got %h expected %h", Mux_Out_r, 32'h1234_5678);
      end
   endtask

   task automatic test_sticky();
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      Entrada1 = 32'hA5A5_0F0F;
      Ctrl     = 2'd3;
      tick();
      Ctrl = 2'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (Sel_Err !== ERR_ON) begin
            errors++;
            $display("FAIL sticky_hold%0d: got %b expected %b", i, Sel_Err, ERR_ON);
         end
         checks++;
         if (Mux_Out_r !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL sticky_r%0d: got %h expected %h", i, Mux_Out_r, 32'hA5A5_0F0F);
         end
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (Sel_Err !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clear: got %b expected %b", Sel_Err, 1'b0);
      end
      checks++;
      if (Mux_Out_r !== 32'h0) begin
         errors++;
         $display("FAIL sticky_clear_r: got %h expected %h", Mux_Out_r, 32'h0);
      end
   endtask

   task automatic test_reset_priority();
      Entrada1 = 32'd1;
      Entrada2 = 32'd2;
      Entrada3 = 32'd3;
      Ctrl     = 2'd2;
      tick();
      reset = 1'b1;
      Ctrl  = 2'd3;
      #1;
      checks++;
      if (Mux_Out !== 32'h0) begin
         errors++;
         $display("FAIL prio_comb: got %h expected %h", Mux_Out, 32'h0);
      end
      tick();
      checks++;
      if (Sel_Err !== 1'b0) begin
         errors++;
         $display("FAIL prio_sel_err: got %b expected %b", Sel_Err, 1'b0);
      end
      checks++;
      if (Mux_Out_r !== 32'h0) begin
         errors++;
         $display("FAIL prio_r: got %h expected %h", Mux_Out_r, 32'h0);
      end
      reset = 1'b0;
      Ctrl  = 2'd0;
   endtask

   task automatic test_full_width();
      logic [31:0] exp;
      Entrada3 = 32'hFFFF_FFFF;
      Entrada1 = 32'h8000_0001;
      Entrada2 = 32'h0;
      for (int i = 0; i < 4; i++) begin
         Ctrl = (i % 2 == 0) ? 2'd2 : 2'd0;
         exp  = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h8000_0001;
         #1;
         checks++;
         if (Mux_Out !== exp) begin
            errors++;
            $display("FAIL width_comb%0d: got %h expected %h", i, Mux_Out, exp);
         end
         tick();
         checks++;
         if (Mux_Out_r !== exp) begin
            errors++;
            $display("FAIL width_r%0d: got %h expected %h", i, Mux_Out_r, exp);
         end
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      clk      = 1'b0;
      clk_run  = 1'b0;
      reset    = 1'b0;
      Ctrl     = 2'd0;
      Entrada1 = '0;
      Entrada2 = '0;
      Entrada3 = '0;

      test_comb();
      clk_run = 1'b1;
      test_reset();
      test_reserved();
      test_registered();
      test_sticky();
      test_reset_priority();
      test_full_width();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
